// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the MEM-stage external SRAM controller.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } sram_state_t;

  localparam int unsigned DEFAULT_BASE_ADDR = 1024;
  localparam int unsigned SRAM_DW           = 16;
  localparam int unsigned CNT_W             = 4;

endpackage

// File: rtl/sram_wait_counter.sv
// Per-half wait counter: clear on state entry, count while a half is on the bus,
// flag the last cycle of the half and the cycle before it.
module sram_wait_counter
  import arm_mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic last_o,
  output logic pre_last_o
);

  localparam int unsigned CW1 = CNT_W + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o     = (cnt_q == CNT_W'(WAIT_CYCLES));
  // Widened so that WAIT_CYCLES=15 still compares correctly.
  assign pre_last_o = ((CW1'(cnt_q) + CW1'(1)) == CW1'(WAIT_CYCLES));

endmodule

// File: rtl/sram_controller.sv
// Splits a 32-bit MEM-stage load/store into two sequenced 16-bit accesses to an
// asynchronous SRAM; ready stays low while the access is in flight.
module sram_controller
  import arm_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'(DEFAULT_BASE_ADDR),
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_o,
  input  logic [SRAM_DW-1:0] sram_dq_i,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  // With no wait cycles each half is a single cycle, so the strobe never drops.
  localparam logic FIRST_IS_LAST = (WAIT_CYCLES == 0);

  sram_state_t state_q, state_d;
  logic               is_wr_q, is_wr_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [SRAM_DW-1:0] dq_q, dq_d;
  logic               oe_q, oe_d;
  logic               we_n_q, we_n_d;

  logic               req;
  logic [31:0]        off;
  logic [SRAM_AW-1:0] lo_addr, hi_addr;
  logic               cnt_clear, cnt_en, cnt_last, cnt_pre_last;
  logic               unused_off;

  assign req        = wr_en | rd_en;
  assign off        = address - BASE_ADDR;
  assign lo_addr    = {off[SRAM_AW:2], 1'b0};
  assign hi_addr    = {off[SRAM_AW:2], 1'b1};
  assign unused_off = ^{off[31:SRAM_AW+1], off[1:0]};

  assign cnt_clear = (state_d != state_q);
  assign cnt_en    = (state_q == LO) || (state_q == HI);

  sram_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_cnt (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (cnt_clear),
    .en_i      (cnt_en),
    .last_o    (cnt_last),
    .pre_last_o(cnt_pre_last)
  );

  // Next-state and next-output decode.
  always_comb begin
    state_d = state_q;
    is_wr_d = is_wr_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    dq_d    = dq_q;
    oe_d    = oe_q;
    we_n_d  = we_n_q;
    ready   = 1'b0;

    case (state_q)
      IDLE: begin
        ready = ~req;
        if (req) begin
          state_d = LO;
          is_wr_d = wr_en;
          addr_d  = lo_addr;
          if (wr_en) begin
            dq_d   = write_data[15:0];
            oe_d   = 1'b1;
            we_n_d = FIRST_IS_LAST;
          end else begin
            oe_d   = 1'b0;
            we_n_d = 1'b1;
          end
        end
      end
      LO: begin
        if (cnt_last) begin
          state_d = HI;
          addr_d  = hi_addr;
          if (is_wr_q) begin
            dq_d   = write_data[31:16];
            we_n_d = FIRST_IS_LAST;
          end else begin
            rdata_d[15:0] = sram_dq_i;
          end
        end else begin
          // Strobe rises one cycle early so data/address are held as it closes.
          we_n_d = ~is_wr_q | cnt_pre_last;
        end
      end
      HI: begin
        if (cnt_last) begin
          state_d = DONE;
          oe_d    = 1'b0;
          we_n_d  = 1'b1;
          if (!is_wr_q) begin
            rdata_d[31:16] = sram_dq_i;
          end
        end else begin
          we_n_d = ~is_wr_q | cnt_pre_last;
        end
      end
      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      is_wr_q <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      dq_q    <= '0;
      oe_q    <= 1'b0;
      we_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      is_wr_q <= is_wr_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      dq_q    <= dq_d;
      oe_q    <= oe_d;
      we_n_q  <= we_n_d;
    end
  end

  assign read_data  = rdata_q;
  assign sram_addr  = addr_q;
  assign sram_dq_o  = dq_q;
  assign sram_dq_oe = oe_q;
  assign sram_we_n  = we_n_q;

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller: word-level reference memory, half-word
// SRAM model, and a monitor that checks each completed access.
module tb_sram_controller;
  import arm_mem_pkg::*;

  localparam int unsigned W       = 2;
  localparam int unsigned AW      = 18;
  localparam logic [31:0] BASE    = 32'd1024;
  localparam int unsigned LOW_CYC = 2 * (W + 1) + 1;

  logic clk = 1'b0;
  logic rst;
  logic mem_clr;

  logic          wr_en, rd_en;
  logic [31:0]   address, write_data, read_data;
  logic          ready;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_o, sram_dq_i;
  logic          sram_dq_oe, sram_we_n;

  logic          wr_en0, rd_en0;
  logic [31:0]   address0, write_data0, read_data0;
  logic          ready0;
  logic [AW-1:0] sram_addr0;
  logic [15:0]   sram_dq_o0, sram_dq_i0;
  logic          sram_dq_oe0, sram_we_n0;

  int checks = 0;
  int failures = 0;
  int issued_n = 0;
  int done_n = 0;

  always #5 clk = ~clk;

  sram_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(W), .SRAM_AW(AW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
  );

  sram_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(0), .SRAM_AW(AW)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en0), .rd_en(rd_en0), .address(address0),
    .write_data(write_data0), .read_data(read_data0), .ready(ready0),
    .sram_addr(sram_addr0), .sram_dq_o(sram_dq_o0), .sram_dq_i(sram_dq_i0),
    .sram_dq_oe(sram_dq_oe0), .sram_we_n(sram_we_n0)
  );

  // Half-word SRAM behind the main DUT; the zero-wait DUT sees a fixed pattern.
  logic [15:0] sram_mem [0:(1<<AW)-1];
  assign sram_dq_i  = sram_mem[sram_addr];
  assign sram_dq_i0 = 16'(sram_addr0) + 16'h1000;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < (1 << AW); i++) sram_mem[i] <= '0;
    end else if (sram_dq_oe && !sram_we_n) begin
      sram_mem[sram_addr] <= sram_dq_o;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        is_wr;
    logic [16:0] word;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int unsigned ref_mem [int unsigned];
  logic [31:0] last_rd = '0;

  // Reference: word-addressed memory; a write wins when both enables are set.
  task automatic issue(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int unsigned wrd;
    int n;
    wrd = ((a - BASE) >> 2) % (1 << (AW - 1));
    e.is_wr = w;
    e.word  = 17'(wrd);
    e.wdata = d;
    if (w) begin
      ref_mem[wrd] = d;
      e.rdata = last_rd;
    end else begin
      e.rdata = ref_mem.exists(wrd) ? ref_mem[wrd] : 32'd0;
      last_rd = e.rdata;
    end
    exp_q.push_back(e);
    issued_n++;
    @(posedge clk); #1;
    wr_en = w; rd_en = r; address = a; write_data = d;
    n = 0;
    @(negedge clk);
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; failures++;
      $display("FAIL done_timeout actual=ready_low expected=ready_high t=%0t", $time);
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  // Monitor: accumulates bus activity while ready is low, scores at completion.
  int low_n, lo_n, hi_n;
  logic in_flight, oe_seen;
  logic [AW-1:0] lo_a, hi_a;
  logic [15:0] lo_d, hi_d;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_flight = 0; low_n = 0; lo_n = 0; hi_n = 0; oe_seen = 0;
      end else if (!ready) begin
        in_flight = 1;
        low_n++;
        if (sram_dq_oe) oe_seen = 1;
        if (!sram_we_n) begin
          if (!sram_addr[0]) begin lo_n++; lo_a = sram_addr; lo_d = sram_dq_o; end
          else begin hi_n++; hi_a = sram_addr; hi_d = sram_dq_o; end
        end
      end else if (in_flight) begin
        done_n++;
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_underflow actual=completion expected=none t=%0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("ready_low_cycles", 32'(low_n), 32'(LOW_CYC));
          chk("read_data", read_data, e.rdata);
          if (e.is_wr) begin
            chk("lo_strobe_cycles", 32'(lo_n), 32'(W));
            chk("hi_strobe_cycles", 32'(hi_n), 32'(W));
            chk("lo_addr", 32'(lo_a), 32'({e.word, 1'b0}));
            chk("hi_addr", 32'(hi_a), 32'({e.word, 1'b1}));
            chk("lo_data", 32'(lo_d), 32'(e.wdata[15:0]));
            chk("hi_data", 32'(hi_d), 32'(e.wdata[31:16]));
          end else begin
            chk("rd_strobes", 32'(lo_n + hi_n), 32'd0);
            chk("rd_oe", 32'(oe_seen), 32'd0);
          end
        end
        in_flight = 0; low_n = 0; lo_n = 0; hi_n = 0; oe_seen = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int n, bad, kind;
    logic [31:0] off, rd0_exp;
    logic [AW-1:0] a_lo, a_hi;
    logic [15:0] d_lo, d_hi;
    logic oe0;

    rst = 1; mem_clr = 1;
    wr_en = 0; rd_en = 0; address = '0; write_data = '0;
    wr_en0 = 0; rd_en0 = 0; address0 = '0; write_data0 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0; mem_clr = 0;
    @(negedge clk);
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_sram_addr", 32'(sram_addr), 32'd0);
    chk("rst_dq_o", 32'(sram_dq_o), 32'd0);
    chk("rst_ready0", 32'(ready0), 32'd1);

    // Store then load held across DONE, then a simultaneous wr/rd.
    issue(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF);
    issue(1'b0, 1'b1, 32'd1028, 32'h0);
    idle(2);
    issue(1'b1, 1'b1, 32'd1040, 32'h12345678);
    idle(1);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      off = (($urandom_range(0, 1) != 0) ? ($urandom() << 19) : 32'd0)
          | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      if (kind < 4)      issue(1'b1, 1'b0, off + BASE, $urandom());
      else if (kind < 8) issue(1'b0, 1'b1, off + BASE, $urandom());
      else               issue(1'b1, 1'b1, off + BASE, $urandom());
      if ($urandom_range(0, 1) != 0) idle($urandom_range(0, 2));
    end
    idle(3);
    chk("sb_pending", 32'(exp_q.size()), 32'd0);
    chk("completions", 32'(done_n), 32'(issued_n));

    // Reset during the high half of a store.
    @(posedge clk); #1;
    wr_en = 1; rd_en = 0; address = BASE; write_data = 32'hCAFEF00D;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_hi_addr", 32'(sram_addr), 32'd1);
    chk("mid_hi_we_n", 32'(sram_we_n), 32'd0);
    rst = 1; wr_en = 0;
    @(posedge clk); #1;
    chk("mid_rst_we_n", 32'(sram_we_n), 32'd1);
    chk("mid_rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    chk("mid_rst_ready", 32'(ready), 32'd1);
    rst = 0;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (!sram_we_n || sram_dq_oe || !ready) bad++;
    end
    chk("post_rst_quiet", 32'(bad), 32'd0);

    // Zero-wait build: load at 1032, then wr+rd together.
    @(posedge clk); #1;
    rd_en0 = 1; address0 = 32'd1032;
    n = 0; a_lo = '0; a_hi = '0;
    @(negedge clk);
    while (!ready0 && n < 50) begin
      n++;
      if (n == 2) a_lo = sram_addr0;
      if (n == 3) a_hi = sram_addr0;
      @(negedge clk);
    end
    rd0_exp = {16'h1000 + 16'd5, 16'h1000 + 16'd4};
    chk("w0_ready_low", 32'(n), 32'd3);
    chk("w0_lo_addr", 32'(a_lo), 32'd4);
    chk("w0_hi_addr", 32'(a_hi), 32'd5);
    chk("w0_read_data", read_data0, rd0_exp);

    @(posedge clk); #1;
    wr_en0 = 1; rd_en0 = 1; write_data0 = 32'hA1B2C3D4;
    n = 0; bad = 0; oe0 = 0; d_lo = '0; d_hi = '0;
    @(negedge clk);
    while (!ready0 && n < 50) begin
      n++;
      if (sram_dq_oe0) oe0 = 1;
      if (!sram_we_n0) bad++;
      if (n == 2) d_lo = sram_dq_o0;
      if (n == 3) d_hi = sram_dq_o0;
      @(negedge clk);
    end
    chk("w0_wr_ready_low", 32'(n), 32'd3);
    chk("w0_wr_oe", 32'(oe0), 32'd1);
    chk("w0_wr_lo_data", 32'(d_lo), 32'h0000C3D4);
    chk("w0_wr_hi_data", 32'(d_hi), 32'h0000A1B2);
    chk("w0_wr_strobes", 32'(bad), 32'd0);
    chk("w0_rd_unchanged", read_data0, rd0_exp);
    @(posedge clk); #1;
    wr_en0 = 0; rd_en0 = 0;
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
